alu_16: RTL and testbench



---
 rtl/alu_16.sv | 115 +++++++++++
 tb/tb_alu_16.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_16.sv
// 16-bit registered ALU: arithmetic, logic, shift/rotate with {C,Z,N,V,P,AC} flags.
module alu_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  input  logic        Cflag,
  input  logic [4:0]  opcode,
  output logic [15:0] result,
  output logic [5:0]  status
);

  localparam int unsigned W = 16;

  localparam logic [4:0] OP_PASSA = 5'b00000;
  localparam logic [4:0] OP_INC   = 5'b00001;
  localparam logic [4:0] OP_PASSB = 5'b00010;
  localparam logic [4:0] OP_DEC   = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_ADC   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SBB   = 5'b00111;
  localparam logic [4:0] OP_AND   = 5'b01000;
  localparam logic [4:0] OP_OR    = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_NOT   = 5'b01011;
  localparam logic [4:0] OP_SHL   = 5'b10000;
  localparam logic [4:0] OP_SHR   = 5'b10001;
  localparam logic [4:0] OP_SAL   = 5'b10010;
  localparam logic [4:0] OP_SAR   = 5'b10011;
  localparam logic [4:0] OP_ROL   = 5'b10100;
  localparam logic [4:0] OP_ROR   = 5'b10101;
  localparam logic [4:0] OP_RCL   = 5'b10110;
  localparam logic [4:0] OP_RCR   = 5'b10111;

  logic [W-1:0] x;
  logic         k;
  logic         arith;
  logic         force_c0;
  logic         valid;
  logic [W:0]   sum;
  logic [W-1:0] r_c;
  logic         c;
  logic         v;
  logic         ac;
  logic [5:0]   status_c;

  // Operand/carry selection, result mux and flag generation.
  always_comb begin
    x        = '0;
    k        = 1'b0;
    arith    = 1'b0;
    force_c0 = 1'b0;
    valid    = 1'b1;
    r_c      = '0;
    c        = 1'b0;
    v        = 1'b0;
    ac       = 1'b0;
    status_c = '0;

    case (opcode)
      OP_PASSA: r_c = A;
      OP_INC:   begin arith = 1'b1; x = '0;    k = 1'b1; force_c0 = 1'b1; end
      OP_PASSB: r_c = B;
      OP_DEC:   begin arith = 1'b1; x = '1;    k = 1'b0; force_c0 = 1'b1; end
      OP_ADD:   begin arith = 1'b1; x = B;     k = 1'b0; end
      OP_ADC:   begin arith = 1'b1; x = B;     k = Cin;  end
      OP_SUB:   begin arith = 1'b1; x = ~B;    k = 1'b1; end
      OP_SBB:   begin arith = 1'b1; x = ~B;    k = ~Cin; end
      OP_AND:   r_c = A & B;
      OP_OR:    r_c = A | B;
      OP_XOR:   r_c = A ^ B;
      OP_NOT:   r_c = ~A;
      OP_SHL,
      OP_SAL:   begin r_c = {A[14:0], 1'b0};  c = A[15]; end
      OP_SHR:   begin r_c = {1'b0, A[15:1]};  c = A[0];  end
      OP_SAR:   begin r_c = {A[15], A[15:1]}; c = A[0];  end
      OP_ROL:   begin r_c = {A[14:0], A[15]}; c = A[15]; end
      OP_ROR:   begin r_c = {A[0], A[15:1]};  c = A[0];  end
      OP_RCL:   begin r_c = {A[14:0], Cflag}; c = A[15]; end
      OP_RCR:   begin r_c = {Cflag, A[15:1]}; c = A[0];  end
      default:  valid = 1'b0;
    endcase

    sum = {1'b0, A} + {1'b0, x} + 17'(k);

    if (arith) begin
      r_c = sum[W-1:0];
      c   = force_c0 ? 1'b0 : sum[W];
      ac  = (5'(A[3:0]) + 5'(x[3:0]) + 5'(k)) > 5'd15;
      v   = (A[15] == x[15]) && (r_c[15] != A[15]);
    end

    // Undefined opcodes report all-zero result and flags, including Z and P.
    if (valid) begin
      status_c = {c, (r_c == '0), r_c[15], v, ~(^r_c), ac};
    end else begin
      r_c      = '0;
      status_c = '0;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      status <= '0;
    end else begin
      result <= r_c;
      status <= status_c;
    end
  end

endmodule

// File: tb/tb_alu_16.sv
// Directed self-checking bench for alu_16.
module tb_alu_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Cflag;
  logic [4:0]  opcode;
  logic [15:0] result;
  logic [5:0]  status;

  int nchecks;
  int nerr;

  alu_16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Cflag  (Cflag),
    .opcode (opcode),
    .result (result),
    .status (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, wait for the capturing edge, sample 1 ns later.
  task automatic apply(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic cf);
    opcode = op; A = a; B = b; Cin = cin; Cflag = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply(5'b00000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      nchecks++;
      if (result !== 16'h0000 || status !== 6'b000000) begin
        nerr++;
        $display("FAIL reset[%0d]: got %h/%b want 0000/000000", i, result, status);
      end
    end
    rst_n = 1'b1;
    apply(5'b00000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    nchecks++;
    if (result !== 16'hFFFF || status !== 6'b001010) begin
      nerr++;
      $display("FAIL reset_release: got %h/%b want ffff/001010", result, status);
    end
  endtask

  // Row layout: {opcode, A, B, Cin, Cflag, exp_result, exp_status}
  task automatic test_arith;
    logic [60:0] tbl [10];
    logic [4:0]  op;
    logic [15:0] a, b, er;
    logic        cin, cf;
    logic [5:0]  es;
    tbl[0] = {5'b00001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h8000, 6'b001101};
    tbl[1] = {5'b00011, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h7FFF, 6'b000100};
    tbl[2] = {5'b00100, 16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 6'b001100};
    tbl[3] = {5'b00101, 16'h0001, 16'hFFF0, 1'b1, 1'b0, 16'hFFF2, 6'b001000};
    tbl[4] = {5'b00110, 16'h1000, 16'h1000, 1'b0, 1'b0, 16'h0000, 6'b110011};
    tbl[5] = {5'b00111, 16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0001, 6'b100001};
    tbl[6] = {5'b00001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 6'b010011};
    tbl[7] = {5'b00011, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 6'b001010};
    tbl[8] = {5'b00100, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002, 6'b000000};
    tbl[9] = {5'b00111, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0002, 6'b100001};
    for (int i = 0; i < 10; i++) begin
      {op, a, b, cin, cf, er, es} = tbl[i];
      apply(op, a, b, cin, cf);
      nchecks++;
      if (result !== er || status !== es) begin
        nerr++;
        $display("FAIL arith[%0d] op=%b: got %h/%b want %h/%b", i, op, result, status, er, es);
      end
    end
  endtask

  task automatic test_logic;
    logic [60:0] tbl [7];
    logic [4:0]  op;
    logic [15:0] a, b, er;
    logic        cin, cf;
    logic [5:0]  es;
    tbl[0] = {5'b00000, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 6'b001010};
    tbl[1] = {5'b00010, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h1234, 6'b000000};
    tbl[2] = {5'b01000, 16'hA5A5, 16'hF00F, 1'b0, 1'b0, 16'hA005, 6'b001010};
    tbl[3] = {5'b01001, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 16'h0FF0, 6'b000010};
    tbl[4] = {5'b01010, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 6'b010010};
    tbl[5] = {5'b01011, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 6'b001010};
    tbl[6] = {5'b01100, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 6'b000000};
    for (int i = 0; i < 7; i++) begin
      {op, a, b, cin, cf, er, es} = tbl[i];
      apply(op, a, b, cin, cf);
      nchecks++;
      if (result !== er || status !== es) begin
        nerr++;
        $display("FAIL logic[%0d] op=%b: got %h/%b want %h/%b", i, op, result, status, er, es);
      end
    end
  endtask

  task automatic test_shift;
    logic [60:0] tbl [8];
    logic [4:0]  op;
    logic [15:0] a, b, er;
    logic        cin, cf;
    logic [5:0]  es;
    tbl[0] = {5'b10000, 16'hC33C, 16'h0000, 1'b0, 1'b0, 16'h8678, 6'b101000};
    tbl[1] = {5'b10010, 16'hC33C, 16'h0000, 1'b0, 1'b0, 16'h8678, 6'b101000};
    tbl[2] = {5'b10001, 16'h1000, 16'h0000, 1'b0, 1'b0, 16'h0800, 6'b000000};
    tbl[3] = {5'b10011, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'hC000, 6'b001010};
    tbl[4] = {5'b10100, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0001, 6'b100000};
    tbl[5] = {5'b10101, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h8000, 6'b101000};
    tbl[6] = {5'b10110, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 6'b000000};
    tbl[7] = {5'b10111, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h8000, 6'b001000};
    for (int i = 0; i < 8; i++) begin
      {op, a, b, cin, cf, er, es} = tbl[i];
      apply(op, a, b, cin, cf);
      nchecks++;
      if (result !== er || status !== es) begin
        nerr++;
        $display("FAIL shift[%0d] op=%b: got %h/%b want %h/%b", i, op, result, status, er, es);
      end
    end
  endtask

  // New operation every cycle; each sample must reflect the previous edge's inputs.
  task automatic test_back_to_back;
    logic [60:0] tbl [6];
    logic [4:0]  op;
    logic [15:0] a, b, er;
    logic        cin, cf;
    logic [5:0]  es;
    tbl[0] = {5'b00100, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 6'b000000};
    tbl[1] = {5'b01000, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 16'h000F, 6'b000010};
    tbl[2] = {5'b11111, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 6'b000000};
    tbl[3] = {5'b10100, 16'h4001, 16'h0000, 1'b0, 1'b0, 16'h8002, 6'b001010};
    tbl[4] = {5'b00110, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 6'b001010};
    tbl[5] = {5'b00010, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 6'b010010};
    for (int i = 0; i < 6; i++) begin
      {op, a, b, cin, cf, er, es} = tbl[i];
      apply(op, a, b, cin, cf);
      nchecks++;
      if (result !== er || status !== es) begin
        nerr++;
        $display("FAIL b2b[%0d] op=%b: got %h/%b want %h/%b", i, op, result, status, er, es);
      end
    end
  endtask

  task automatic test_midstream_reset;
    rst_n = 1'b1;
    apply(5'b00100, 16'h0001, 16'h0001, 1'b0, 1'b0);
    nchecks++;
    if (result !== 16'h0002 || status !== 6'b000000) begin
      nerr++;
      $display("FAIL mid_pre: got %h/%b want 0002/000000", result, status);
    end
    rst_n = 1'b0;
    apply(5'b00100, 16'h7000, 16'h1000, 1'b0, 1'b0);
    nchecks++;
    if (result !== 16'h0000 || status !== 6'b000000) begin
      nerr++;
      $display("FAIL mid_reset: got %h/%b want 0000/000000", result, status);
    end
    rst_n = 1'b1;
    apply(5'b00100, 16'h0003, 16'h0003, 1'b0, 1'b0);
    nchecks++;
    if (result !== 16'h0006 || status !== 6'b000010) begin
      nerr++;
      $display("FAIL mid_post: got %h/%b want 0006/000010", result, status);
    end
  endtask

  initial begin
    nchecks = 0;
    nerr    = 0;
    rst_n   = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Cflag = 1'b0; opcode = '0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_back_to_back();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
